// File: rtl/iso_ctrl_reg_file_multi.sv
// AXI-Lite control register file for a multi-interface isolation core.
// Each interface has a decoupler/protocol-verifier pair. The register file
// holds per-interface and global decouple requests, one-shot timeout clears,
// and sticky, maskable timeout interrupts that share one aggregated irq line.
module iso_ctrl_reg_file_multi #(
  parameter int NUM_IFACES = 1,
  parameter int STAT_W     = 5,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // write address
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  // write data
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  // write response
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  // read data
  output logic [31:0]                    rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  // isolation core side
  output logic [NUM_IFACES-1:0]          decouple,
  input  logic [NUM_IFACES-1:0]          decouple_done,
  input  logic [NUM_IFACES*STAT_W-1:0]   decouple_status_vector,
  input  logic [NUM_IFACES-1:0]          timeout_error_irq,
  output logic [NUM_IFACES-1:0]          timeout_error_clear,
  input  logic [NUM_IFACES*STAT_W-1:0]   timeout_status_vector,
  output logic                           irq
);

  // Words 0..3 are global; each interface then owns a DECOUPLE/VERIFIER pair.
  localparam int NUM_WORDS = 4 + 2 * NUM_IFACES;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel holding slots and response
  logic                  awFull_q, awFull_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic                  wFull_q, wFull_d;
  logic [31:0]           wData_q, wData_d;
  logic [3:0]            wStrb_q, wStrb_d;
  logic                  bValid_q, bValid_d;
  logic [1:0]            bResp_q, bResp_d;

  // Architectural registers
  logic                  decoupleAll_q, decoupleAll_d;
  logic [NUM_IFACES-1:0] decoupleReg_q, decoupleReg_d;
  logic [NUM_IFACES-1:0] irqStatus_q, irqStatus_d;
  logic [NUM_IFACES-1:0] irqEnable_q, irqEnable_d;
  logic [NUM_IFACES-1:0] clearPulse_q, clearPulse_d;
  logic                  irq_q, irq_d;

  // Read channel
  logic                  arPend_q, arPend_d;
  logic [ADDR_WIDTH-1:0] arAddr_q, arAddr_d;
  logic                  rValid_q, rValid_d;
  logic [31:0]           rData_q, rData_d;
  logic [1:0]            rResp_q, rResp_d;

  // Decode helpers
  logic                  commit;
  logic [31:0]           wWord;
  logic                  wMapped;
  logic [31:0]           byteMask;
  logic [NUM_IFACES-1:0] w1cMask;
  logic [31:0]           rWord;
  logic [31:0]           rdMux;
  logic [1:0]            rdResp;

  // Low address bits and the upper data/strobe bits are not decoded for every
  // NUM_IFACES; fold them here so they are visibly consumed.
  logic unusedBits;
  assign unusedBits = ^{awAddr_q[1:0], arAddr_q[1:0], wData_q, wStrb_q};

  assign commit  = awFull_q & wFull_q & ~bValid_q;
  assign wWord   = 32'(awAddr_q[ADDR_WIDTH-1:2]);
  assign wMapped = (wWord < 32'(NUM_WORDS));
  assign rWord   = 32'(arAddr_q[ADDR_WIDTH-1:2]);

  assign awready             = ~awFull_q;
  assign wready              = ~wFull_q;
  assign bvalid              = bValid_q;
  assign bresp               = bResp_q;
  assign arready             = ~rValid_q & ~arPend_q;
  assign rvalid              = rValid_q;
  assign rdata               = rData_q;
  assign rresp               = rResp_q;
  assign decouple            = decoupleReg_q | {NUM_IFACES{decoupleAll_q}};
  assign timeout_error_clear = clearPulse_q;
  assign irq                 = irq_q;

  // Expand the byte strobes into a per-bit write mask.
  always_comb begin
    byteMask = '0;
    for (int k = 0; k < 4; k++) begin
      byteMask[8*k +: 8] = {8{wStrb_q[k]}};
    end
  end

  // Fill the AW/W slots independently, free both on commit, track the response.
  always_comb begin
    awFull_d = awFull_q;
    awAddr_d = awAddr_q;
    wFull_d  = wFull_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    bValid_d = bValid_q;
    bResp_d  = bResp_q;
    if (commit) begin
      awFull_d = 1'b0;
      wFull_d  = 1'b0;
      bValid_d = 1'b1;
      bResp_d  = wMapped ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (awvalid && !awFull_q) begin
        awFull_d = 1'b1;
        awAddr_d = awaddr;
      end
      if (wvalid && !wFull_q) begin
        wFull_d = 1'b1;
        wData_d = wdata;
        wStrb_d = wstrb;
      end
      if (bValid_q && bready) begin
        bValid_d = 1'b0;
      end
    end
  end

  // Apply a committed write to the register set; timeout inputs set status and win over W1C.
  always_comb begin
    decoupleAll_d = decoupleAll_q;
    decoupleReg_d = decoupleReg_q;
    irqEnable_d   = irqEnable_q;
    clearPulse_d  = '0;
    w1cMask       = '0;
    if (commit && wMapped) begin
      if (wWord == 32'd0 && wStrb_q[0]) begin
        decoupleAll_d = wData_q[0];
      end
      if (wWord == 32'd1) begin
        w1cMask = wData_q[NUM_IFACES-1:0] & byteMask[NUM_IFACES-1:0];
      end
      if (wWord == 32'd2) begin
        irqEnable_d = (irqEnable_q & ~byteMask[NUM_IFACES-1:0]) |
                      (wData_q[NUM_IFACES-1:0] & byteMask[NUM_IFACES-1:0]);
      end
      for (int i = 0; i < NUM_IFACES; i++) begin
        if (wWord == 32'(4 + 2*i) && wStrb_q[0]) begin
          decoupleReg_d[i] = wData_q[0];
        end
        if (wWord == 32'(5 + 2*i) && wStrb_q[0] && wData_q[0]) begin
          clearPulse_d[i] = 1'b1;
        end
      end
    end
    irqStatus_d = (irqStatus_q & ~w1cMask) | timeout_error_irq;
    irq_d       = |(irqStatus_q & irqEnable_q);
  end

  // Read data multiplexer over the register map; status fields come from live inputs.
  always_comb begin
    rdMux  = '0;
    rdResp = RESP_OKAY;
    if (rWord >= 32'(NUM_WORDS)) begin
      rdResp = RESP_SLVERR;
    end else if (rWord == 32'd0) begin
      rdMux[0]    = decoupleAll_q;
      rdMux[15:8] = 8'(NUM_IFACES);
    end else if (rWord == 32'd1) begin
      rdMux[NUM_IFACES-1:0] = irqStatus_q;
    end else if (rWord == 32'd2) begin
      rdMux[NUM_IFACES-1:0] = irqEnable_q;
    end else begin
      for (int i = 0; i < NUM_IFACES; i++) begin
        if (rWord == 32'(4 + 2*i)) begin
          rdMux[0]          = decoupleReg_q[i];
          rdMux[1]          = decouple_done[i];
          rdMux[STAT_W+1:2] = decouple_status_vector[i*STAT_W +: STAT_W];
        end
        if (rWord == 32'(5 + 2*i)) begin
          rdMux[1]          = timeout_error_irq[i];
          rdMux[STAT_W+1:2] = timeout_status_vector[i*STAT_W +: STAT_W];
        end
      end
    end
  end

  // One outstanding read: capture AR, load data on the following edge, hold until rready.
  always_comb begin
    arPend_d = arPend_q;
    arAddr_d = arAddr_q;
    rValid_d = rValid_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    if (arPend_q) begin
      arPend_d = 1'b0;
      rValid_d = 1'b1;
      rData_d  = rdMux;
      rResp_d  = rdResp;
    end else if (arvalid && !rValid_q) begin
      arPend_d = 1'b1;
      arAddr_d = araddr;
    end
    if (rValid_q && rready) begin
      rValid_d = 1'b0;
    end
  end

  // Write channel state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awFull_q <= 1'b0;
      awAddr_q <= '0;
      wFull_q  <= 1'b0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      bValid_q <= 1'b0;
      bResp_q  <= RESP_OKAY;
    end else begin
      awFull_q <= awFull_d;
      awAddr_q <= awAddr_d;
      wFull_q  <= wFull_d;
      wData_q  <= wData_d;
      wStrb_q  <= wStrb_d;
      bValid_q <= bValid_d;
      bResp_q  <= bResp_d;
    end
  end

  // Control, interrupt and clear-pulse registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      decoupleAll_q <= 1'b0;
      decoupleReg_q <= '0;
      irqStatus_q   <= '0;
      irqEnable_q   <= '0;
      clearPulse_q  <= '0;
      irq_q         <= 1'b0;
    end else begin
      decoupleAll_q <= decoupleAll_d;
      decoupleReg_q <= decoupleReg_d;
      irqStatus_q   <= irqStatus_d;
      irqEnable_q   <= irqEnable_d;
      clearPulse_q  <= clearPulse_d;
      irq_q         <= irq_d;
    end
  end

  // Read channel state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arPend_q <= 1'b0;
      arAddr_q <= '0;
      rValid_q <= 1'b0;
      rData_q  <= '0;
      rResp_q  <= RESP_OKAY;
    end else begin
      arPend_q <= arPend_d;
      arAddr_q <= arAddr_d;
      rValid_q <= rValid_d;
      rData_q  <= rData_d;
      rResp_q  <= rResp_d;
    end
  end

endmodule

// File: tb/tb_iso_ctrl_reg_file_multi.sv
// Bench for iso_ctrl_reg_file_multi with four interfaces. A register-level
// model of the map (decouple bits, sticky status, enable mask) predicts every
// response, read value and output.
module tb_iso_ctrl_reg_file_multi;

  localparam int N  = 4;
  localparam int SW = 5;
  localparam int AW = 12;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [N-1:0]  decouple;
  logic [N-1:0]  decoupleDone;
  logic [N*SW-1:0] decStatusVec;
  logic [N-1:0]  tei;
  logic [N-1:0]  teClear;
  logic [N*SW-1:0] toStatusVec;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         refDecAll;
  bit [N-1:0] refDecReg;
  bit [N-1:0] refIrqStatus;
  bit [N-1:0] refIrqEn;

  iso_ctrl_reg_file_multi #(.NUM_IFACES(N), .STAT_W(SW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .decouple(decouple), .decouple_done(decoupleDone),
    .decouple_status_vector(decStatusVec),
    .timeout_error_irq(tei), .timeout_error_clear(teClear),
    .timeout_status_vector(toStatusVec), .irq(irq)
  );

  always #5 aclk = ~aclk;

  // Watchdog against any unbounded stall.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] expDecouple();
    return refDecReg | {N{refDecAll}};
  endfunction

  // Model of a write: returns the expected response and updates model state.
  function automatic logic [1:0] modelWrite(logic [AW-1:0] addr, logic [31:0] data, logic [3:0] strb);
    int word;
    logic [31:0] m;
    word = int'(addr[AW-1:2]);
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{strb[k]}};
    if (word >= 4 + 2*N) return 2'b10;
    if (word == 0) begin
      if (strb[0]) refDecAll = data[0];
    end else if (word == 1) begin
      refIrqStatus = (refIrqStatus & ~(data[N-1:0] & m[N-1:0])) | tei;
    end else if (word == 2) begin
      refIrqEn = (refIrqEn & ~m[N-1:0]) | (data[N-1:0] & m[N-1:0]);
    end else if (word >= 4 && (word % 2) == 0) begin
      if (strb[0]) refDecReg[(word-4)/2] = data[0];
    end
    return 2'b00;
  endfunction

  // Model of a read: returns {rresp, rdata}.
  function automatic logic [33:0] modelRead(logic [AW-1:0] addr);
    int word;
    int i;
    word = int'(addr[AW-1:2]);
    if (word >= 4 + 2*N) return {2'b10, 32'h0};
    case (word)
      0: return {2'b00, 16'h0, 8'(N), 7'h0, refDecAll};
      1: return {2'b00, 28'h0, refIrqStatus};
      2: return {2'b00, 28'h0, refIrqEn};
      3: return {2'b00, 32'h0};
      default: begin
        i = (word - 4) / 2;
        if ((word % 2) == 0)
          return {2'b00, 25'h0, decStatusVec[i*SW +: SW], decoupleDone[i], refDecReg[i]};
        else
          return {2'b00, 25'h0, toStatusVec[i*SW +: SW], tei[i], 1'b0};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AXI-Lite write with independent AW/W start delays.
  task automatic axiWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDly, input int wDly, output logic [1:0] resp);
    int n;
    fork
      begin : awChan
        int na;
        bit hs;
        repeat (awDly) tick();
        awaddr = addr; awvalid = 1'b1; na = 0; hs = 1'b0;
        while (!hs && na < 20) begin hs = awready; tick(); na++; end
        awvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("[TB] FAIL aw_handshake addr=%h: awready never 1", addr); end
      end
      begin : wChan
        int nw;
        bit hs;
        repeat (wDly) tick();
        wdata = data; wstrb = strb; wvalid = 1'b1; nw = 0; hs = 1'b0;
        while (!hs && nw < 20) begin hs = wready; tick(); nw++; end
        wvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("[TB] FAIL w_handshake addr=%h: wready never 1", addr); end
      end
    join
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (!bvalid) begin errors++; $display("[TB] FAIL bvalid_timeout addr=%h: got 0 want 1", addr); end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // AXI-Lite read, accepting the data as soon as it is valid.
  task automatic axiRead(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bit hs;
    araddr = addr; arvalid = 1'b1; n = 0; hs = 1'b0;
    while (!hs && n < 20) begin hs = arready; tick(); n++; end
    arvalid = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("[TB] FAIL ar_handshake addr=%h: arready never 1", addr); end
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    checks++;
    if (!rvalid) begin errors++; $display("[TB] FAIL rvalid_timeout addr=%h: got 0 want 1", addr); end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [AW-1:0] addr);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    e = modelRead(addr);
    axiRead(addr, d, r);
    checks++;
    if ({r, d} !== e) begin
      errors++;
      $display("[TB] FAIL %s addr=%h: got resp=%b data=%h want resp=%b data=%h", name, addr, r, d, e[33:32], e[31:0]);
    end
  endtask

  task automatic writeCheck(input string name, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int awDly, input int wDly);
    logic [1:0] r;
    logic [1:0] e;
    axiWrite(addr, data, strb, awDly, wDly, r);
    e = modelWrite(addr, data, strb);
    checks++;
    if (r !== e) begin
      errors++;
      $display("[TB] FAIL %s addr=%h: got bresp=%b want %b", name, addr, r, e);
    end
  endtask

  task automatic checkOutputs(input string name);
    checks++;
    if (decouple !== expDecouple()) begin
      errors++; $display("[TB] FAIL %s_decouple: got %b want %b", name, decouple, expDecouple());
    end
    checks++;
    if (irq !== |(refIrqStatus & refIrqEn)) begin
      errors++; $display("[TB] FAIL %s_irq: got %b want %b", name, irq, |(refIrqStatus & refIrqEn));
    end
    checks++;
    if (teClear !== '0) begin
      errors++; $display("[TB] FAIL %s_clear: got %b want 0", name, teClear);
    end
  endtask

  task automatic test_reset();
    int n;
    writeCheck("rst_pre_global", 12'h000, 32'h1, 4'hF, 0, 0);
    writeCheck("rst_pre_enable", 12'h008, 32'hF, 4'hF, 0, 0);
    tei = 4'b0100; refIrqStatus |= tei;
    tick(); tick();
    tei = '0;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_irq: got %b want 1", irq); end
    // Leave an AW in its slot, then reset mid-cycle.
    awaddr = 12'h010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    refDecAll = 0; refDecReg = '0; refIrqStatus = '0; refIrqEn = '0;
    checks++;
    if ({bvalid, rvalid, decouple, teClear, irq} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_outputs: got bvalid=%b rvalid=%b decouple=%b clear=%b irq=%b want all 0",
               bvalid, rvalid, decouple, teClear, irq);
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("[TB] FAIL rst_ready: got aw/w/ar=%b want 111", {awready, wready, arready});
    end
    tick(); tick();
    aresetn = 1'b1;
    tick();
    // The dropped AW must not pair with a fresh W.
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    checks++;
    if (bvalid !== 1'b0 || decouple !== '0) begin
      errors++; $display("[TB] FAIL rst_stale_aw: got bvalid=%b decouple=%b want 0/0", bvalid, decouple);
    end
    awaddr = 12'h00C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_drain: got bvalid=%b bresp=%b want 1/00", bvalid, bresp);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checkOutputs("rst_post");
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL wfirst_slots: got wready=%b awready=%b bvalid=%b want 0/1/0", wready, awready, bvalid);
    end
    awaddr = 12'h010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wfirst_early: got bvalid=%b want 0", bvalid); end
    tick();
    void'(modelWrite(12'h010, 32'h1, 4'hF));
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || decouple !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL wfirst_commit: got bvalid=%b bresp=%b decouple=%b want 1/00/0001", bvalid, bresp, decouple);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wfirst_bdone: got bvalid=%b want 0", bvalid); end
  endtask

  task automatic test_global_decouple();
    writeCheck("glob_write", 12'h000, 32'h1, 4'hF, 1, 0);
    checks++;
    if (decouple !== 4'hF) begin errors++; $display("[TB] FAIL glob_decouple: got %h want F", decouple); end
    readCheck("glob_read", 12'h000);
    writeCheck("glob_strb0", 12'h000, 32'h0, 4'b1110, 0, 0);
    checks++;
    if (decouple !== 4'hF) begin errors++; $display("[TB] FAIL glob_strb_gate: got %h want F", decouple); end
    writeCheck("glob_off", 12'h000, 32'h0, 4'h1, 0, 2);
    checkOutputs("glob");
  endtask

  task automatic test_sticky_irq();
    writeCheck("irq_en", 12'h008, 32'h2, 4'hF, 0, 0);
    tei = 4'b0010; refIrqStatus |= tei;
    tick();
    tei = '0;
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_assert: got %b want 1", irq); end
    readCheck("irq_status_set", 12'h004);
    readCheck("irq_status_again", 12'h004);
    writeCheck("irq_w1c", 12'h004, 32'h2, 4'hF, 0, 0);
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_deassert: got %b want 0", irq); end
    readCheck("irq_status_clr", 12'h004);
    tei = 4'b0010; refIrqStatus |= tei;
    writeCheck("irq_w1c_race", 12'h004, 32'h2, 4'hF, 0, 0);
    tei = '0;
    tick();
    readCheck("irq_set_wins", 12'h004);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set_wins_out: got %b want 1", irq); end
    writeCheck("irq_w1c_strb", 12'h004, 32'h2, 4'b1110, 0, 0);
    readCheck("irq_strb_kept", 12'h004);
    writeCheck("irq_cleanup", 12'h004, 32'hF, 4'hF, 0, 0);
    checkOutputs("irq");
  endtask

  task automatic test_clear_pulse();
    logic [3:0] strbs [2];
    strbs[0] = 4'hF;
    strbs[1] = 4'b1110;
    for (int t = 0; t < 2; t++) begin
      int hiCnt;
      int otherCnt;
      hiCnt = 0; otherCnt = 0;
      fork
        writeCheck("clr_write", 12'h014, 32'h1, strbs[t], 0, 0);
        begin
          repeat (12) begin
            @(negedge aclk);
            if (teClear[0]) hiCnt++;
            if (teClear[N-1:1] != '0) otherCnt++;
          end
        end
      join
      checks++;
      if (hiCnt !== ((t == 0) ? 1 : 0) || otherCnt !== 0) begin
        errors++;
        $display("[TB] FAIL clr_pulse strb=%b: got %0d high cycles (%0d on other bits) want %0d (0)",
                 strbs[t], hiCnt, otherCnt, (t == 0) ? 1 : 0);
      end
    end
    readCheck("clr_reads_zero", 12'h014);
  endtask

  task automatic test_unmapped();
    readCheck("unmap_read", 12'hFFC);
    writeCheck("unmap_write", 12'hFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    checkOutputs("unmap");
    readCheck("unmap_global", 12'h000);
    readCheck("unmap_enable", 12'h008);
    readCheck("reserved_read", 12'h00C);
    writeCheck("reserved_write", 12'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic [33:0] e;
    int n;
    bit hs;
    writeCheck("bp_enable", 12'h008, 32'h5, 4'hF, 0, 0);
    e = modelRead(12'h008);
    araddr = 12'h008; arvalid = 1'b1; n = 0; hs = 1'b0;
    while (!hs && n < 20) begin hs = arready; tick(); n++; end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    d0 = rdata;
    checks++;
    if (rvalid !== 1'b1 || {rresp, d0} !== e) begin
      errors++; $display("[TB] FAIL bp_first: got rvalid=%b data=%h want 1/%h", rvalid, d0, e[31:0]);
    end
    arvalid = 1'b1;
    araddr = 12'h000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got rvalid=%b rdata=%h arready=%b want 1/%h/0", c, rvalid, rdata, arready, d0);
      end
    end
    arvalid = 1'b0;
    rready = 1'b1; tick(); rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [AW-1:0] addr;
      int word;
      decoupleDone = N'($urandom);
      decStatusVec = (N*SW)'({$urandom, $urandom});
      toStatusVec  = (N*SW)'({$urandom, $urandom});
      tei = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      refIrqStatus |= tei;
      word = int'($urandom_range(0, 4 + 2*N));
      if (word == 4 + 2*N) word = int'($urandom_range(4 + 2*N, 1023));
      addr = AW'(word * 4 + int'($urandom_range(0, 3)));
      tick();
      if ($urandom_range(0, 1) == 0)
        writeCheck("rand_write", addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        readCheck("rand_read", addr);
      checkOutputs("rand");
    end
    tei = '0;
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    decoupleDone = '0; decStatusVec = '0; tei = '0; toStatusVec = '0;
    refDecAll = 0; refDecReg = '0; refIrqStatus = '0; refIrqEn = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    checks++;
    if ({bvalid, rvalid, decouple, teClear, irq, awready, wready, arready} !== {11'b0, 3'b111}) begin
      errors++; $display("[TB] FAIL initial_reset: outputs not in reset state");
    end
    test_reset();
    test_w_before_aw();
    test_global_decouple();
    test_sticky_irq();
    test_clear_pulse();
    test_unmapped();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
